vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480 @ 60 Hz raster generator:
//   default porch/sync/active widths, the derived line and frame totals,
//   the sync window bounds, and the 10-bit coordinate type used on the
//   x/y buses.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int CLK_DIV_DEF  = 4;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Sync is low for START <= count < END.
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each
//   inc and wraps. sync_n and active are registered from the next-state
//   count so they always describe the same position as count.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   inc        : advance the count by one this cycle
//   count      : current position (registered)
//   sync_n     : low while count is inside the sync window (registered)
//   active     : high while count < ACTIVE (registered, 0 in reset)
//   wrap       : combinational, high when this inc takes count TOTAL-1 -> 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t count,
  output logic   sync_n,
  output logic   active,
  output logic   wrap
);

  localparam int     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END    = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  coord_t r_count;
  coord_t w_count_nxt;
  logic   r_sync_n;
  logic   r_active;

  always_comb begin
    w_count_nxt = r_count;
    if (inc) begin
      w_count_nxt = (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign wrap = inc && (r_count == LAST);

  // Decodes are refreshed every clock, not only on inc: this is what makes
  // active rise on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_sync_n <= 1'b1;
      r_active <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_sync_n <= !((w_count_nxt >= SYNC_START) && (w_count_nxt < SYNC_END));
      r_active <= (w_count_nxt < ACT_END);
    end
  end

  assign count  = r_count;
  assign sync_n = r_sync_n;
  assign active = r_active;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480 @ 60 Hz raster/sync generator on a single clock. The pixel rate
//   is a clock enable (pix_tick) from an integer divider; x/y advance on the
//   edge where pix_tick is high.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   x, y        : current raster position
//   hsync/vsync : active-low sync pulses
//   video_on    : x < H_ACTIVE and y < V_ACTIVE (0 in reset)
//   pix_tick    : one-clock pulse per pixel period
//   frame_start : one-clock pulse when (x,y) wraps to (0,0)
//   frame_cnt   : 16-bit frame counter, present only when VGA_FRAME_CNT_EN
//                 is defined
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output coord_t      x,
  output coord_t      y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_pix_tick;
  logic             r_frame_start;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_active;
  logic             w_v_active;

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

  // pix_tick is registered from the next divider value, so it is high in
  // exactly the cycle where r_div == CLK_DIV-1 (always, for CLK_DIV == 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div      <= w_div_nxt;
      r_pix_tick <= (w_div_nxt == DIV_LAST);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (r_pix_tick),
    .count  (x),
    .sync_n (hsync),
    .active (w_h_active),
    .wrap   (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_h_wrap),
    .count  (y),
    .sync_n (vsync),
    .active (w_v_active),
    .wrap   (w_v_wrap)
  );

  // Both operands are flops loaded on the same edge, so video_on never
  // skews against x/y.
  assign video_on = w_h_active & w_v_active;

  // A full-frame wrap happens only when both axes wrap on one edge, so the
  // reset-exit (0,0) never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign pix_tick    = r_pix_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Three instances share one clock/reset: default 640x480 timing, and a
//   shrunken geometry at CLK_DIV=3 and CLK_DIV=1 so whole frames fit in a
//   short run. Expected outputs come from a closed-form model: the number
//   of clock edges since reset release gives the number of pixels advanced,
//   and x/y/frame count follow by division and modulo. Random run lengths
//   between asynchronous mid-frame resets.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int S_HA = 10, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        tick;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  always #5 clk = ~clk;

  coord_t      d_x, d_y, a_x, a_y, b_x, b_y;
  logic        d_hs, d_vs, d_von, d_tk, d_fs;
  logic        a_hs, a_vs, a_von, a_tk, a_fs;
  logic        b_hs, b_vs, b_von, b_tk, b_fs;
  logic [15:0] d_fc, a_fc, b_fc;

`ifndef VGA_FRAME_CNT_EN
  assign d_fc = '0;
  assign a_fc = '0;
  assign b_fc = '0;
`endif

  vga_sync_gen u_dut_def (
    .clk(clk), .rst_n(rst_n), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_von), .pix_tick(d_tk), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_dut_div3 (
    .clk(clk), .rst_n(rst_n), .x(a_x), .y(a_y), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .pix_tick(a_tk), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .x(b_x), .y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .pix_tick(b_tk), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  // Edge n after release: pix_tick is high when n mod D == D-1, and the
  // raster advances on every edge that follows a tick cycle.
  function automatic exp_t model(input int edges, input int d,
                                 input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp);
    exp_t e;
    int ht, vt, p, px, py;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (edges == 0) return e;
    p  = edges / d - ((d == 1) ? 1 : 0);
    px = p % ht;
    py = (p / ht) % vt;
    e.x    = 10'(px);
    e.y    = 10'(py);
    e.fc   = 16'(p / (ht * vt));
    e.hs   = !((px >= ha + hfp) && (px < ha + hfp + hs));
    e.vs   = !((py >= va + vfp) && (py < va + vfp + vs));
    e.von  = (px < ha) && (py < va);
    e.tick = ((edges % d) == d - 1);
    e.fs   = ((edges % d) == 0) && (edges >= 2) && ((p % (ht * vt)) == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s (edge %0d): got %0d want %0d", tag, n, obs, expv);
    end
  endtask

  task automatic chk_inst(input string nm, input exp_t e,
                          input coord_t ox, input coord_t oy,
                          input logic ohs, input logic ovs, input logic ovon,
                          input logic otk, input logic ofs, input logic [15:0] ofc);
    chk({nm, ".x"},           32'(ox),   32'(e.x));
    chk({nm, ".y"},           32'(oy),   32'(e.y));
    chk({nm, ".hsync"},       32'(ohs),  32'(e.hs));
    chk({nm, ".vsync"},       32'(ovs),  32'(e.vs));
    chk({nm, ".video_on"},    32'(ovon), 32'(e.von));
    chk({nm, ".pix_tick"},    32'(otk),  32'(e.tick));
    chk({nm, ".frame_start"}, 32'(ofs),  32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    chk({nm, ".frame_cnt"},   32'(ofc),  32'(e.fc));
`endif
  endtask

  task automatic check_all();
    exp_t e;
    e = model(n, CLK_DIV_DEF, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
              V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
    chk_inst("def", e, d_x, d_y, d_hs, d_vs, d_von, d_tk, d_fs, d_fc);
    e = model(n, 3, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
    chk_inst("div3", e, a_x, a_y, a_hs, a_vs, a_von, a_tk, a_fs, a_fc);
    e = model(n, 1, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
    chk_inst("div1", e, b_x, b_y, b_hs, b_vs, b_von, b_tk, b_fs, b_fc);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      #1;
      check_all();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    release_reset();

    // Covers two full default-timing lines (656/752 sync edges, 799->0 wrap)
    // and many full frames of the small geometries.
    run(7000);

    for (int k = 0; k < 6; k++) begin
      run(int'($urandom_range(40, 1200)));
      #2;
      rst_n = 1'b0;
      n = 0;
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      release_reset();
    end

    run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
